seq_mult16: RTL and testbench

SEQ_MULT16 -- requirements
Module: seq_mult16

---
 rtl/seq_mult16_if.sv | 22 ++
 rtl/seq_mult16.sv | 89 ++++++++
 tb/tb_seq_mult16.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult16_if.sv
// rtl/seq_mult16_if.sv - operand/result bundle for the 16x16 sequential multiplier
// Signals: start, a[15:0], b[15:0] (requester -> multiplier);
//          p[31:0], busy, done (multiplier -> requester).
// master: the requesting side, slave: the multiplier.
interface seq_mult16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] p;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  p, busy, done
  );

  modport slave (
    input  start, a, b,
    output p, busy, done
  );
endinterface

// File: rtl/seq_mult16.sv
// rtl/seq_mult16.sv - unsigned 16x16 shift-add multiplier, one step per clock
// Ports: clk  - sole clock, rising edge
//        rst  - asynchronous active-high reset
//        bus  - seq_mult16_if.slave: start/a/b in, p/busy/done out
module seq_mult16 (
  input  logic         clk,
  input  logic         rst,
  seq_mult16_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] acc_hi_q, acc_hi_d;
  logic [15:0] acc_lo_q, acc_lo_d;
  logic [31:0] p_q, p_d;

  // 17-bit partial sum: bit 16 is the carry-out, which is shifted into
  // acc_hi[15] rather than dropped, so 0xFFFF*0xFFFF stays exact.
  logic [16:0] sum;
  logic [31:0] step;

  always_comb begin
    sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 17'd0);
    step = {sum, acc_lo_q[15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 16'd0;
      acc_hi_q <= 16'd0;
      acc_lo_q <= 16'd0;
      p_q      <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    p_d      = p_q;

    case (state_q)
      S_BUSY: begin
        // start is deliberately not looked at here: requests while busy are ignored
        {acc_hi_d, acc_lo_d} = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          p_d     = step;
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE
        if (bus.start) begin
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = 16'd0;
          cnt_d    = 5'd0;
          state_d  = S_BUSY;
        end else begin
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  assign bus.p    = p_q;
  assign bus.busy = (state_q == S_BUSY);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_mult16.sv
// tb/tb_seq_mult16.sv - self-checking bench for seq_mult16
module tb_seq_mult16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_mult16_if bus ();

  seq_mult16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Issues one request and waits for done; a/b are scrambled right after
  // acceptance. lat counts edges after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    #1;
    n_checks++;
    if ({bus.p, bus.busy, bus.done} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got p=%h busy=%b done=%b, want 0/0/0", bus.p, bus.busy, bus.done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.p, bus.busy, bus.done} !== 34'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got p=%h busy=%b done=%b, want 0/0/0", bus.p, bus.busy, bus.done);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] vp [4];
    int lat, bc;
    va[0] = 16'h0000; vb[0] = 16'h0000; vp[0] = 32'h00000000;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vp[1] = 32'hFFFE0001;
    va[2] = 16'h00FF; vb[2] = 16'h0101; vp[2] = 32'h0000FFFF;
    va[3] = 16'h8000; vb[3] = 16'h0002; vp[3] = 32'h00010000;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, bc);
      n_checks++;
      if (bus.p !== vp[i]) begin
        n_fail++;
        $display("FAIL vector_%0d_p: got %h, want %h", i, bus.p, vp[i]);
      end
      n_checks++;
      if (lat != 16) begin
        n_fail++;
        $display("FAIL vector_%0d_latency: got %0d, want 16", i, lat);
      end
      n_checks++;
      if (bc != 16) begin
        n_fail++;
        $display("FAIL vector_%0d_busy_cycles: got %0d, want 16", i, bc);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, lat, bc);
      n_checks++;
      if (bus.p !== ref_mul(ra, rb)) begin
        n_fail++;
        $display("FAIL random_%0d_p (%h*%h): got %h, want %h", i, ra, rb, bus.p, ref_mul(ra, rb));
      end
      n_checks++;
      if (lat != 16) begin
        n_fail++;
        $display("FAIL random_%0d_latency: got %0d, want 16", i, lat);
      end
    end
  endtask

  task automatic test_hold;
    logic [31:0] held;
    int lat, bc;
    run_op(16'h0123, 16'h0456, lat, bc);
    held = ref_mul(16'h0123, 16'h0456);
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.p !== held || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: got p=%h done=%b, want p=%h done=0", bus.p, bus.done, held);
    end
    bus.start = 1'b1;
    bus.a     = 16'h0002;
    bus.b     = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.p !== held || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy: got p=%h busy=%b, want p=%h busy=1", bus.p, bus.busy, held);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int busy_cnt, done_cnt, done_at;
    logic [31:0] p_at_done;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = -1;
    p_at_done = 32'h0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h0010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) bus.a = 16'hFFFF;
      if (k == 15) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = k;
          p_at_done = bus.p;
        end
      end
    end
    n_checks++;
    if (p_at_done !== 32'h00012340) begin
      n_fail++;
      $display("FAIL busy_start_p: got %h, want 00012340", p_at_done);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_start_done_pulses: got %0d, want 1", done_cnt);
    end
    n_checks++;
    if (busy_cnt != 16) begin
      n_fail++;
      $display("FAIL busy_start_busy_cycles: got %0d, want 16", busy_cnt);
    end
    n_checks++;
    if (done_at != 16) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d, want 16", done_at);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ra, rb;
    int lat, bc, gap;
    logic busy_next;
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_op(ra, rb, lat, bc);
    n_checks++;
    if (bus.p !== ref_mul(ra, rb) || lat != 16) begin
      n_fail++;
      $display("FAIL b2b_first: got p=%h lat=%0d, want p=%h lat=16", bus.p, lat, ref_mul(ra, rb));
    end
    bus.start = 1'b1;
    bus.a     = 16'h0003;
    bus.b     = 16'h0005;
    gap       = -1;
    busy_next = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) begin
        busy_next = bus.busy;
        bus.start = 1'b0;
        bus.a     = 16'hFFFF;
      end
      if (bus.done) begin
        gap = j;
        break;
      end
    end
    n_checks++;
    if (busy_next !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy_next: got %b, want 1", busy_next);
    end
    n_checks++;
    if (gap != 17) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d, want 17", gap);
    end
    n_checks++;
    if (bus.p !== 32'h0000000F) begin
      n_fail++;
      $display("FAIL b2b_p: got %h, want 0000000f", bus.p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int done_cnt, lat, bc;
    logic p_nonzero;
    done_cnt  = 0;
    p_nonzero = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.p, bus.busy, bus.done} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got p=%h busy=%b done=%b, want 0/0/0", bus.p, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.p !== 32'd0) p_nonzero = 1'b1;
    end
    n_checks++;
    if (done_cnt != 0 || p_nonzero) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done_pulses=%0d p_changed=%b, want 0/0", done_cnt, p_nonzero);
    end
    run_op(16'h0002, 16'h0007, lat, bc);
    n_checks++;
    if (bus.p !== 32'h0000000E || lat != 16) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got p=%h lat=%0d, want p=0000000e lat=16", bus.p, lat);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_vectors;
    test_random;
    test_hold;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
